rotor_stepper: RTL and testbench

- Upstream neighbour of the seven-segment display stage. Holds the three Enigma rotor positions and steps them once per accepted keypress, following the real machine's rules, including the middle-rotor double-step.
- Drives the rotor position values shown on the position digits.
- Passes the pressed letter downstream with a valid/ready handshake, so the cipher path always sees the post-step positions.

---
 rtl/enigma_pkg.sv | 28 ++
 rtl/rotor_counter.sv | 28 ++
 rtl/rotor_stepper.sv | 100 ++++++++++
 tb/tb_rotor_stepper.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/enigma_pkg.sv
// Shared Enigma letter encoding, rotor stepper FSM states and mod-26 helpers.
package enigma_pkg;

    localparam int ALPHA_SIZE = 26;
    localparam int LETTER_W   = 6;

    typedef logic [LETTER_W-1:0] letter_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        STEP = 2'd1,
        OUT  = 2'd2
    } state_e;

    localparam letter_t L_A = 6'd0;
    localparam letter_t L_E = 6'd4;
    localparam letter_t L_V = 6'd21;
    localparam letter_t L_Z = 6'd25;

    function automatic logic is_letter(letter_t v);
        return v <= L_Z;
    endfunction

    function automatic letter_t next_letter(letter_t v);
        return (v == L_Z) ? L_A : v + 6'd1;
    endfunction

endpackage

// File: rtl/rotor_counter.sv
// One rotor position: mod-26 counter with guarded parallel load and step enable.
module rotor_counter
    import enigma_pkg::*;
#(
    parameter logic [LETTER_W-1:0] INIT = L_A
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                load,
    input  logic [LETTER_W-1:0] load_val,
    input  logic                step,
    output logic [LETTER_W-1:0] pos,
    output logic                load_bad
);

    // Out-of-range load values leave the rotor where it is.
    assign load_bad = load && !is_letter(load_val);

    always_ff @(posedge clk) begin
        if (rst)
            pos <= INIT;
        else if (load && is_letter(load_val))
            pos <= load_val;
        else if (step)
            pos <= next_letter(pos);
    end

endmodule

// File: rtl/rotor_stepper.sv
// Steps three Enigma rotors once per accepted key (with middle-rotor double-step)
// and hands the key downstream once the positions reflect the step.
module rotor_stepper
    import enigma_pkg::*;
#(
    parameter logic [LETTER_W-1:0] NOTCH0 = 6'd21,
    parameter logic [LETTER_W-1:0] NOTCH1 = 6'd4,
    parameter logic [LETTER_W-1:0] INIT0  = 6'd0,
    parameter logic [LETTER_W-1:0] INIT1  = 6'd0,
    parameter logic [LETTER_W-1:0] INIT2  = 6'd0
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                key_valid,
    output logic                key_ready,
    input  logic [LETTER_W-1:0] key_in,
    input  logic                load,
    input  logic [LETTER_W-1:0] load_r0,
    input  logic [LETTER_W-1:0] load_r1,
    input  logic [LETTER_W-1:0] load_r2,
    output logic                load_err,
    output logic [LETTER_W-1:0] r0_pos,
    output logic [LETTER_W-1:0] r1_pos,
    output logic [LETTER_W-1:0] r2_pos,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [LETTER_W-1:0] out_letter
);

    localparam int NUM_ROTORS = 3;
    localparam logic [NUM_ROTORS-1:0][LETTER_W-1:0] INIT_POS = {INIT2, INIT1, INIT0};

    state_e                               state;
    logic                                 load_acc;
    logic [NUM_ROTORS-1:0][LETTER_W-1:0]  load_val;
    logic [NUM_ROTORS-1:0][LETTER_W-1:0]  pos;
    logic [NUM_ROTORS-1:0]                step_en;
    logic [NUM_ROTORS-1:0]                bad;

    assign load_acc = (state == IDLE) && load;
    assign load_val = {load_r2, load_r1, load_r0};
    assign key_ready = (state == IDLE) && !load;

    // Pre-step positions decide all three enables; r1 == NOTCH1 drives the double-step.
    assign step_en[0] = (state == STEP);
    assign step_en[1] = (state == STEP) && ((pos[0] == NOTCH0) || (pos[1] == NOTCH1));
    assign step_en[2] = (state == STEP) && (pos[1] == NOTCH1);

    for (genvar i = 0; i < NUM_ROTORS; i++) begin : g_rotor
        rotor_counter #(.INIT(INIT_POS[i])) u_rc (
            .clk      (clk),
            .rst      (rst),
            .load     (load_acc),
            .load_val (load_val[i]),
            .step     (step_en[i]),
            .pos      (pos[i]),
            .load_bad (bad[i])
        );
    end

    assign r0_pos = pos[0];
    assign r1_pos = pos[1];
    assign r2_pos = pos[2];

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            out_valid  <= 1'b0;
            out_letter <= L_A;
            load_err   <= 1'b0;
        end else begin
            load_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (load)
                        load_err <= |bad;
                    else if (key_valid && is_letter(key_in)) begin
                        out_letter <= key_in;
                        state      <= STEP;
                    end
                end
                STEP: begin
                    state     <= OUT;
                    out_valid <= 1'b1;
                end
                OUT: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                    end
                end
                default: begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rotor_stepper.sv
// Directed bench for rotor_stepper: per-cycle comparison against a behavioural
// model plus literal position/handshake expectations.
module tb_rotor_stepper;

    logic       clk = 1'b0;
    logic       rst;
    logic       key_valid;
    logic       key_ready;
    logic [5:0] key_in;
    logic       load;
    logic [5:0] load_r0, load_r1, load_r2;
    logic       load_err;
    logic [5:0] r0_pos, r1_pos, r2_pos;
    logic       out_valid;
    logic       out_ready;
    logic [5:0] out_letter;

    int checks = 0;
    int failures = 0;

    rotor_stepper dut (
        .clk        (clk),
        .rst        (rst),
        .key_valid  (key_valid),
        .key_ready  (key_ready),
        .key_in     (key_in),
        .load       (load),
        .load_r0    (load_r0),
        .load_r1    (load_r1),
        .load_r2    (load_r2),
        .load_err   (load_err),
        .r0_pos     (r0_pos),
        .r1_pos     (r1_pos),
        .r2_pos     (r2_pos),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .out_letter (out_letter)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Behavioural model: rotor positions as integers; a key waits one cycle to
    // step, then sits on the output until taken.
    int m_pos[3];
    int m_phase;   // 0 waiting for key, 1 key taken, 2 letter offered
    int m_let;
    int m_err;

    always @(posedge clk) begin
        int nr0, nr1, nr2;
        if (rst) begin
            m_pos = '{0, 0, 0};
            m_phase = 0;
            m_err = 0;
        end else begin
            m_err = 0;
            if (m_phase == 0) begin
                if (load) begin
                    if (load_r0 < 26) m_pos[0] = load_r0; else m_err = 1;
                    if (load_r1 < 26) m_pos[1] = load_r1; else m_err = 1;
                    if (load_r2 < 26) m_pos[2] = load_r2; else m_err = 1;
                end else if (key_valid && key_in < 26) begin
                    m_let = key_in;
                    m_phase = 1;
                end
            end else if (m_phase == 1) begin
                nr0 = (m_pos[0] + 1) % 26;
                nr1 = (m_pos[0] == 21 || m_pos[1] == 4) ? (m_pos[1] + 1) % 26 : m_pos[1];
                nr2 = (m_pos[1] == 4) ? (m_pos[2] + 1) % 26 : m_pos[2];
                m_pos = '{nr0, nr1, nr2};
                m_phase = 2;
            end else if (out_ready) begin
                m_phase = 0;
            end
        end
        #2;
        check("model_r0", r0_pos, m_pos[0]);
        check("model_r1", r1_pos, m_pos[1]);
        check("model_r2", r2_pos, m_pos[2]);
        check("model_out_valid", out_valid, (m_phase == 2) ? 1 : 0);
        check("model_key_ready", key_ready, (m_phase == 0 && !load) ? 1 : 0);
        check("model_load_err", load_err, m_err);
        if (m_phase == 2) check("model_out_letter", out_letter, m_let);
    end

    task automatic cyc();
        @(negedge clk);
    endtask

    task automatic check_pos(input string name, input int a, input int b, input int c);
        check({name, "_r0"}, r0_pos, a);
        check({name, "_r1"}, r1_pos, b);
        check({name, "_r2"}, r2_pos, c);
    endtask

    task automatic do_load(input int a, input int b, input int c);
        load = 1'b1; load_r0 = 6'(a); load_r1 = 6'(b); load_r2 = 6'(c);
        cyc();
        load = 1'b0;
    endtask

    // Key accepted at the first edge, stepped and offered at the next, taken at the third.
    task automatic press(input int k, input int a, input int b, input int c);
        key_valid = 1'b1; key_in = 6'(k);
        cyc();
        key_valid = 1'b0;
        check("press_step_no_valid", out_valid, 0);
        cyc();
        check("press_out_valid", out_valid, 1);
        check("press_out_letter", out_letter, k);
        check_pos("press_pos", a, b, c);
        cyc();
        check("press_back_idle", key_ready, 1);
        check_pos("press_after", a, b, c);
    endtask

    initial begin
        rst = 1'b1; key_valid = 1'b0; key_in = '0; load = 1'b0;
        load_r0 = '0; load_r1 = '0; load_r2 = '0; out_ready = 1'b1;
        cyc(); cyc();
        check_pos("reset", 0, 0, 0);
        check("reset_key_ready", key_ready, 1);
        check("reset_out_valid", out_valid, 0);
        check("reset_load_err", load_err, 0);
        rst = 1'b0;
        cyc();

        // Double-step across the middle notch
        do_load(20, 3, 0);
        press(7, 21, 3, 0);
        press(11, 22, 4, 0);
        press(25, 23, 5, 1);

        // Wrap cases
        do_load(25, 25, 25); press(0, 0, 25, 25);
        do_load(21, 25, 3);  press(1, 22, 0, 3);
        do_load(0, 4, 25);   press(2, 1, 5, 0);

        // Backpressure with key_valid and load toggling meanwhile
        out_ready = 1'b0;
        key_valid = 1'b1; key_in = 6'd3;
        cyc();
        key_valid = 1'b0;
        cyc();
        for (int i = 0; i < 5; i++) begin
            key_valid = i[0]; key_in = 6'd9;
            load = ~i[0]; load_r0 = 6'd1; load_r1 = 6'd2; load_r2 = 6'd3;
            cyc();
            check("bp_out_valid", out_valid, 1);
            check("bp_out_letter", out_letter, 3);
            check("bp_key_ready", key_ready, 0);
            check_pos("bp_pos", 2, 5, 0);
        end
        key_valid = 1'b0; load = 1'b0; out_ready = 1'b1;
        cyc();
        check("bp_release_valid", out_valid, 0);
        check_pos("bp_release_pos", 2, 5, 0);

        // Out-of-range key is consumed without a step
        key_valid = 1'b1; key_in = 6'd63;
        cyc();
        key_valid = 1'b0;
        cyc();
        check("badkey_no_valid", out_valid, 0);
        check_pos("badkey_pos", 2, 5, 0);
        cyc();
        check("badkey_no_valid2", out_valid, 0);

        // Out-of-range load value on r1 only
        do_load(5, 30, 7);
        check("loaderr_pulse", load_err, 1);
        check_pos("loaderr_pos", 5, 5, 7);
        cyc();
        check("loaderr_clear", load_err, 0);

        // Load and key in the same cycle: load wins
        load = 1'b1; load_r0 = 6'd1; load_r1 = 6'd1; load_r2 = 6'd1;
        key_valid = 1'b1; key_in = 6'd2;
        cyc();
        load = 1'b0; key_valid = 1'b0;
        check_pos("loadkey_pos", 1, 1, 1);
        cyc();
        check("loadkey_no_valid", out_valid, 0);
        check_pos("loadkey_pos2", 1, 1, 1);

        // Reset while stepping
        key_valid = 1'b1; key_in = 6'd4;
        cyc();
        key_valid = 1'b0; rst = 1'b1;
        cyc();
        rst = 1'b0;
        check_pos("rst_step_pos", 0, 0, 0);
        check("rst_step_valid", out_valid, 0);

        // Reset while offering the letter
        do_load(10, 10, 10);
        out_ready = 1'b0;
        key_valid = 1'b1; key_in = 6'd5;
        cyc();
        key_valid = 1'b0;
        cyc();
        check("rst_out_pre_valid", out_valid, 1);
        check_pos("rst_out_pre_pos", 11, 10, 10);
        rst = 1'b1;
        cyc();
        rst = 1'b0; out_ready = 1'b1;
        check_pos("rst_out_pos", 0, 0, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_key_ready", key_ready, 1);
        cyc(); cyc();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
